// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//
// Conditions raw slide-switch / push-button pins for the 8-bit PIO in_port.
// Each bit is passed through a two-flop synchroniser and then a debounce
// filter. A new level is accepted only after it has been stable at the
// synchroniser output for DEBOUNCE_CYCLES consecutive cycles. The bench-facing
// outputs are a clean level bus plus one-cycle rise/fall pulses.
//
// Parameters:
//   WIDTH           number of switch bits (PIO in_port width)
//   DEBOUNCE_CYCLES stable cycles needed to accept a level, 1..2**CNT_W-1
//   CNT_W           width of each per-bit debounce counter
//
// Ports:
//   clk          in   system clock, the only clock
//   reset_n      in   synchronous active-low reset, sampled on rising clk
//   sw_raw       in   [WIDTH] asynchronous raw switch pins
//   sw_out       out  [WIDTH] debounced level, drives PIO in_port
//   sw_rise      out  [WIDTH] one-cycle pulse when sw_out[i] goes 0->1
//   sw_fall      out  [WIDTH] one-cycle pulse when sw_out[i] goes 1->0
//   edge_clear   in   [WIDTH] write-one-to-clear strobe   (optional)
//   edge_capture out  [WIDTH] sticky edge-seen bits        (optional)
//
// Optional feature: define SWITCH_DEBOUNCER_EDGE_CAPTURE_EN to add the
// edge_clear / edge_capture ports and the sticky capture register.
//
// Latency: a level held steady on sw_raw appears on sw_out at rising edge
// DEBOUNCE_CYCLES+2, counting the edge that first samples it as edge 1.
// All outputs are registered.
// ---------------------------------------------------------------------------
module switch_debouncer #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
`ifdef SWITCH_DEBOUNCER_EDGE_CAPTURE_EN
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
`endif
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    // -----------------------------------------------------------------------
    // Elaboration-time configuration check
    // -----------------------------------------------------------------------
    if ((DEBOUNCE_CYCLES < 1) ||
        (longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1))) begin : gen_bad_cfg
        $error("switch_debouncer: DEBOUNCE_CYCLES must be in 1..2**CNT_W-1");
    end

    // Terminal count: the count reaching this value on a still-differing
    // input means DEBOUNCE_CYCLES consecutive differing samples were seen.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // -----------------------------------------------------------------------
    // Two-flop synchroniser; only sync2_q is ever looked at by the filter.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Per-bit debounce filter
    // -----------------------------------------------------------------------
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] == out_q[i]) begin
                // Input agrees with the accepted level: any partial count
                // belonged to a glitch and is thrown away.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                out_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // Pulses are computed from the next level so they line up with the
        // cycle in which sw_out actually changes.
        rise_d = out_d & ~out_q;
        fall_d = out_q & ~out_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '{default: '0};
        end else begin
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sw_out  = out_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;

`ifdef SWITCH_DEBOUNCER_EDGE_CAPTURE_EN
    // -----------------------------------------------------------------------
    // Sticky edge capture. Set comes from the visible pulses and is applied
    // after the clear, so a clear coinciding with a new edge leaves it set.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] capture_q, capture_d;

    always_comb begin
        capture_d = (capture_q & ~edge_clear) | rise_q | fall_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            capture_q <= '0;
        end else begin
            capture_q <= capture_d;
        end
    end

    assign edge_capture = capture_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (DEBOUNCE_CYCLES = 4).
// The driver applies one input vector per cycle and pushes the expected
// post-edge outputs into a queue; a monitor on the falling edge pops and
// compares. The reference model accepts a new level for bit i when the last
// D filter-input samples all disagree with the current level.
module tb_switch_debouncer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
`ifdef SWITCH_DEBOUNCER_EDGE_CAPTURE_EN
    logic [W-1:0] edge_clear;
    logic [W-1:0] edge_capture;
`endif

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw_raw      (sw_raw),
`ifdef SWITCH_DEBOUNCER_EDGE_CAPTURE_EN
        .edge_clear  (edge_clear),
        .edge_capture(edge_capture),
`endif
        .sw_out      (sw_out),
        .sw_rise     (sw_rise),
        .sw_fall     (sw_fall)
    );

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] cap;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_out = '0, m_rise = '0, m_fall = '0, m_cap = '0;
    logic [W-1:0] hist[$];
    logic [W-1:0] clr_v = '0;

    task automatic model_edge(input logic [W-1:0] raw, input logic rn, input logic [W-1:0] clr);
        exp_t         e;
        logic [W-1:0] nxt;
        logic         all_diff;
        if (!rn) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_cap = '0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            nxt = m_out;
            if (hist.size() == D) begin
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++) begin
                        if (hist[j][i] == m_out[i]) all_diff = 1'b0;
                    end
                    if (all_diff) nxt[i] = ~m_out[i];
                end
            end
            m_cap  = (m_cap & ~clr) | m_rise | m_fall;
            m_rise = nxt & ~m_out;
            m_fall = m_out & ~nxt;
            m_out  = nxt;
            m_s2   = m_s1;
            m_s1   = raw;
        end
        e.out  = m_out;
        e.rise = m_rise;
        e.fall = m_fall;
        e.cap  = m_cap;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [W-1:0] raw, input logic rn);
        @(negedge clk);
        sw_raw  = raw;
        reset_n = rn;
`ifdef SWITCH_DEBOUNCER_EDGE_CAPTURE_EN
        edge_clear = clr_v;
`endif
        @(posedge clk);
        model_edge(raw, rn, clr_v);
    endtask

    task automatic hold(input logic [W-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b1);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({sw_out, sw_rise, sw_fall} !== {e.out, e.rise, e.fall}) begin
                n_fail++;
                $display("FAIL outputs @%0t: out/rise/fall got %h/%h/%h expected %h/%h/%h",
                         $time, sw_out, sw_rise, sw_fall, e.out, e.rise, e.fall);
            end
            if ((sw_rise & sw_fall) !== '0) begin
                n_fail++;
                $display("FAIL rise_fall_overlap @%0t: got %h expected 00", $time,
                         sw_rise & sw_fall);
            end
`ifdef SWITCH_DEBOUNCER_EDGE_CAPTURE_EN
            n_tests++;
            if (edge_capture !== e.cap) begin
                n_fail++;
                $display("FAIL edge_capture @%0t: got %h expected %h", $time, edge_capture,
                         e.cap);
            end
`endif
        end
    end

    initial begin
        int lat;
        logic [W-1:0] r;
        sw_raw  = '0;
        reset_n = 1'b0;
`ifdef SWITCH_DEBOUNCER_EDGE_CAPTURE_EN
        edge_clear = '0;
`endif
        // Reset, then quiet inputs
        step('0, 1'b0);
        step('0, 1'b0);
        hold(8'h00, 8);

        // Single-bit rise: expect sw_rise on edge D+2 after the change
        lat = 0;
        step(8'h01, 1'b1);
        #1;
        if (sw_rise == 8'h01) lat = 1;
        for (int k = 2; k <= 10; k++) begin
            step(8'h01, 1'b1);
            #1;
            if (lat == 0 && sw_rise == 8'h01) lat = k;
        end
        n_tests++;
        if (lat != D + 2) begin
            n_fail++;
            $display("FAIL rise_latency: got edge %0d expected edge %0d", lat, D + 2);
        end
        hold(8'h00, 8);

        // Short glitch on bit 3 is rejected, then a long hold is accepted
        hold(8'h08, D - 1);
        hold(8'h00, 8);
        hold(8'h08, D + 4);

        // All ones, then a multi-bit fall in one cycle
        hold(8'hFF, 8);
        hold(8'h5A, 10);

        // Reset in the middle of a count
        hold(8'h00, 8);
        hold(8'h80, 4);
        step(8'h80, 1'b0);
        hold(8'h80, 10);

        // Clear held high while a bit toggles: set must win
        clr_v = 8'h01;
        hold(8'h81, 8);
        hold(8'h80, 8);
        clr_v = 8'h00;

        // Randomized phase: sparse per-bit toggles, occasional reset and clear
        r = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            clr_v = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            step(r, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end
        clr_v = '0;

        // Drain with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
